video_frame_checker: RTL and testbench

- Passive monitor on an 8-bit sop/eop/valid/ready video stream, ready latency 0.
- Sits directly downstream of stream_latency_1_to_0, tapping the same wires that feed vid_to_file. It never drives ready.
- Per frame, it checks framing against ROWS x COLS, counts good frames and produces a modular pixel checksum.
- Bench scoreboards use it to confirm that frames crossed the async FIFO intact.

---
 rtl/video_frame_checker.sv | 249 ++++++++++++++++++++++++
 tb/tb_video_frame_checker.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/video_frame_checker.sv
// ---------------------------------------------------------------------------
// video_frame_checker
//
// Passive monitor for an 8-bit sop/eop/valid/ready video stream with ready
// latency 0. It never drives ready. A beat is valid & ready, and only beats
// are acted on.
//
// For each frame the checker does the following:
//   - checks the frame length against ROWS x COLS,
//   - counts good frames,
//   - keeps a modular pixel checksum of the last frame that ended.
//
// Ports:
//   clk, srst     stream clock, synchronous active-high reset
//   clr           clears err_sticky and frame_count
//   data/sop/eop/valid/ready   observed stream
//   frame_done    one-cycle pulse, a frame ended (good or bad)
//   frame_ok      qualifies frame_done, the frame had exact length
//   err_short, err_long, err_sop, err_orphan   one-cycle error pulses
//   err_sticky    {orphan, sop, long, short}, OR-accumulated
//   frame_count   good frames seen, wraps
//   checksum      sum mod 2^CSUM_BITS of the last ended frame
//   in_frame      FSM is in the FRAME state
//
// Optional feature, enabled by defining VIDEO_FRAME_CHECK_MINMAX_EN:
//   pix_min, pix_max   minimum and maximum pixel of the last ended frame
// ---------------------------------------------------------------------------
module video_frame_checker #(
    parameter int BITS      = 8,
    parameter int ROWS      = 240,
    parameter int COLS      = 320,
    parameter int CSUM_BITS = 16,
    parameter int CNT_BITS  = 16
) (
    input  logic                 clk,
    input  logic                 srst,
    input  logic                 clr,
    input  logic [BITS-1:0]      data,
    input  logic                 sop,
    input  logic                 eop,
    input  logic                 valid,
    input  logic                 ready,
    output logic                 frame_done,
    output logic                 frame_ok,
    output logic                 err_short,
    output logic                 err_long,
    output logic                 err_sop,
    output logic                 err_orphan,
    output logic [3:0]           err_sticky,
    output logic [CNT_BITS-1:0]  frame_count,
    output logic [CSUM_BITS-1:0] checksum,
    output logic                 in_frame
`ifdef VIDEO_FRAME_CHECK_MINMAX_EN
    ,
    output logic [BITS-1:0]      pix_min,
    output logic [BITS-1:0]      pix_max
`endif
);

    localparam int FRAME_LEN = ROWS * COLS;
    localparam int CW        = $clog2(FRAME_LEN + 1);

    typedef enum logic {SEEK, FRAME} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [CSUM_BITS-1:0] acc_q, acc_d;
    logic [CSUM_BITS-1:0] checksum_q, checksum_d;
    logic [CNT_BITS-1:0]  frame_count_q, frame_count_d;
    logic [3:0]           err_sticky_q, err_sticky_d;
    logic                 frame_done_q, frame_done_d;
    logic                 frame_ok_q, frame_ok_d;
    logic                 err_short_q, err_short_d;
    logic                 err_long_q, err_long_d;
    logic                 err_sop_q, err_sop_d;
    logic                 err_orphan_q, err_orphan_d;

    logic                 beat;
    logic                 frame_good;
    logic [CW-1:0]        cnt_inc;
    logic [CSUM_BITS-1:0] data_ext;
    logic [CSUM_BITS-1:0] acc_sum;

`ifdef VIDEO_FRAME_CHECK_MINMAX_EN
    logic [BITS-1:0] run_min_q, run_min_d, run_max_q, run_max_d;
    logic [BITS-1:0] pix_min_q, pix_min_d, pix_max_q, pix_max_d;
    logic [BITS-1:0] nxt_min, nxt_max;
`endif

    always_comb begin
        beat     = valid & ready;
        cnt_inc  = cnt_q + CW'(1);
        data_ext = CSUM_BITS'(data);
        acc_sum  = acc_q + data_ext;

        state_d      = state_q;
        cnt_d        = cnt_q;
        acc_d        = acc_q;
        checksum_d   = checksum_q;
        frame_done_d = 1'b0;
        frame_ok_d   = 1'b0;
        err_short_d  = 1'b0;
        err_long_d   = 1'b0;
        err_sop_d    = 1'b0;
        err_orphan_d = 1'b0;
        frame_good   = 1'b0;
`ifdef VIDEO_FRAME_CHECK_MINMAX_EN
        nxt_min   = (data < run_min_q) ? data : run_min_q;
        nxt_max   = (data > run_max_q) ? data : run_max_q;
        run_min_d = run_min_q;
        run_max_d = run_max_q;
        pix_min_d = pix_min_q;
        pix_max_d = pix_max_q;
`endif

        if (beat) begin
            if (sop) begin
                // A sop inside a frame aborts it. Report the old frame first,
                // then let this beat start a new frame.
                if (state_q == FRAME) begin
                    err_sop_d    = 1'b1;
                    frame_done_d = 1'b1;
                    checksum_d   = acc_q;
`ifdef VIDEO_FRAME_CHECK_MINMAX_EN
                    pix_min_d = run_min_q;
                    pix_max_d = run_max_q;
`endif
                end
                acc_d = data_ext;
                cnt_d = CW'(1);
`ifdef VIDEO_FRAME_CHECK_MINMAX_EN
                run_min_d = data;
                run_max_d = data;
`endif
                // A sop beat that also finishes the frame (eop, or a
                // one-pixel frame size) ends the frame right away.
                if (eop || FRAME_LEN == 1) begin
                    frame_done_d = 1'b1;
                    checksum_d   = data_ext;
                    state_d      = SEEK;
`ifdef VIDEO_FRAME_CHECK_MINMAX_EN
                    pix_min_d = data;
                    pix_max_d = data;
`endif
                    if (FRAME_LEN == 1 && eop) begin
                        frame_ok_d = 1'b1;
                        frame_good = 1'b1;
                    end else if (FRAME_LEN == 1) begin
                        err_long_d = 1'b1;
                    end else begin
                        err_short_d = 1'b1;
                    end
                end else begin
                    state_d = FRAME;
                end
            end else if (state_q == FRAME) begin
                acc_d = acc_sum;
                cnt_d = cnt_inc;
`ifdef VIDEO_FRAME_CHECK_MINMAX_EN
                run_min_d = nxt_min;
                run_max_d = nxt_max;
`endif
                if (cnt_inc == CW'(FRAME_LEN) || eop) begin
                    frame_done_d = 1'b1;
                    checksum_d   = acc_sum;
                    state_d      = SEEK;
`ifdef VIDEO_FRAME_CHECK_MINMAX_EN
                    pix_min_d = nxt_min;
                    pix_max_d = nxt_max;
`endif
                    if (cnt_inc != CW'(FRAME_LEN)) begin
                        err_short_d = 1'b1;
                    end else if (eop) begin
                        frame_ok_d = 1'b1;
                        frame_good = 1'b1;
                    end else begin
                        err_long_d = 1'b1;
                    end
                end
            end else begin
                err_orphan_d = 1'b1;
            end
        end

        // A set from an error pulse wins over a coincident clr, and a good
        // frame that coincides with clr leaves the counter at one.
        err_sticky_d  = (clr ? 4'b0000 : err_sticky_q)
                        | {err_orphan_d, err_sop_d, err_long_d, err_short_d};
        frame_count_d = (clr ? '0 : frame_count_q) + (frame_good ? CNT_BITS'(1) : '0);
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state_q       <= SEEK;
            cnt_q         <= '0;
            acc_q         <= '0;
            checksum_q    <= '0;
            frame_count_q <= '0;
            err_sticky_q  <= '0;
            frame_done_q  <= 1'b0;
            frame_ok_q    <= 1'b0;
            err_short_q   <= 1'b0;
            err_long_q    <= 1'b0;
            err_sop_q     <= 1'b0;
            err_orphan_q  <= 1'b0;
`ifdef VIDEO_FRAME_CHECK_MINMAX_EN
            run_min_q <= '1;
            run_max_q <= '0;
            pix_min_q <= '1;
            pix_max_q <= '0;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            acc_q         <= acc_d;
            checksum_q    <= checksum_d;
            frame_count_q <= frame_count_d;
            err_sticky_q  <= err_sticky_d;
            frame_done_q  <= frame_done_d;
            frame_ok_q    <= frame_ok_d;
            err_short_q   <= err_short_d;
            err_long_q    <= err_long_d;
            err_sop_q     <= err_sop_d;
            err_orphan_q  <= err_orphan_d;
`ifdef VIDEO_FRAME_CHECK_MINMAX_EN
            run_min_q <= run_min_d;
            run_max_q <= run_max_d;
            pix_min_q <= pix_min_d;
            pix_max_q <= pix_max_d;
`endif
        end
    end

    assign frame_done  = frame_done_q;
    assign frame_ok    = frame_ok_q;
    assign err_short   = err_short_q;
    assign err_long    = err_long_q;
    assign err_sop     = err_sop_q;
    assign err_orphan  = err_orphan_q;
    assign err_sticky  = err_sticky_q;
    assign frame_count = frame_count_q;
    assign checksum    = checksum_q;
    assign in_frame    = (state_q == FRAME);
`ifdef VIDEO_FRAME_CHECK_MINMAX_EN
    assign pix_min = pix_min_q;
    assign pix_max = pix_max_q;
`endif

endmodule

// File: tb/tb_video_frame_checker.sv
// ---------------------------------------------------------------------------
// tb_video_frame_checker
//
// Directed testbench for video_frame_checker. The DUT uses a small 2x3 frame
// and a 2-bit frame counter, so counter wrap is reached quickly.
// Expected values are computed by hand.
// ---------------------------------------------------------------------------
module tb_video_frame_checker;

    logic       clk;
    logic       srst;
    logic       clr;
    logic [7:0] data;
    logic       sop;
    logic       eop;
    logic       valid;
    logic       ready;
    logic       frame_done;
    logic       frame_ok;
    logic       err_short;
    logic       err_long;
    logic       err_sop;
    logic       err_orphan;
    logic [3:0] err_sticky;
    logic [1:0] frame_count;
    logic [15:0] checksum;
    logic       in_frame;
`ifdef VIDEO_FRAME_CHECK_MINMAX_EN
    logic [7:0] pix_min;
    logic [7:0] pix_max;
    logic [7:0] mm_pix [6];
`endif

    int total_count;
    int bad_count;

    video_frame_checker #(
        .BITS(8), .ROWS(2), .COLS(3), .CSUM_BITS(16), .CNT_BITS(2)
    ) dut (
        .clk(clk), .srst(srst), .clr(clr), .data(data), .sop(sop), .eop(eop),
        .valid(valid), .ready(ready), .frame_done(frame_done), .frame_ok(frame_ok),
        .err_short(err_short), .err_long(err_long), .err_sop(err_sop),
        .err_orphan(err_orphan), .err_sticky(err_sticky), .frame_count(frame_count),
        .checksum(checksum), .in_frame(in_frame)
`ifdef VIDEO_FRAME_CHECK_MINMAX_EN
        , .pix_min(pix_min), .pix_max(pix_max)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_count++;
        if (got !== exp) begin
            bad_count++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of stream inputs. On return the registered outputs
    // show the effect of that cycle.
    task automatic applyStimulus(input logic v, input logic r, input logic s,
                                 input logic e, input logic [7:0] d);
        valid = v;
        ready = r;
        sop   = s;
        eop   = e;
        data  = d;
        @(posedge clk);
        #1;
    endtask

    // Send a good 6-pixel frame with data base..base+5.
    task automatic sendGoodFrame(input logic [7:0] base);
        for (int i = 0; i < 6; i++)
            applyStimulus(1'b1, 1'b1, i == 0, i == 5, base + 8'(i));
    endtask

    initial begin
        total_count = 0;
        bad_count   = 0;
        srst = 1'b1; clr = 1'b0;
        valid = 1'b0; ready = 1'b0; sop = 1'b0; eop = 1'b0; data = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_done", frame_done, 0);
        checkOutput("rst_sticky", err_sticky, 0);
        checkOutput("rst_count", frame_count, 0);
        checkOutput("rst_csum", checksum, 0);
        checkOutput("rst_inframe", in_frame, 0);
`ifdef VIDEO_FRAME_CHECK_MINMAX_EN
        checkOutput("rst_min", pix_min, 8'hFF);
        checkOutput("rst_max", pix_max, 0);
`endif
        srst = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);

        // Good frame with ready held high.
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 8'd1);
        checkOutput("good_inframe", in_frame, 1);
        for (int i = 2; i <= 5; i++)
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'(i));
        checkOutput("good_nodone", frame_done, 0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 8'd6);
        checkOutput("good_done", frame_done, 1);
        checkOutput("good_ok", frame_ok, 1);
        checkOutput("good_csum", checksum, 21);
        checkOutput("good_count", frame_count, 1);
        checkOutput("good_sticky", err_sticky, 0);
        checkOutput("good_inframe_end", in_frame, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        checkOutput("good_pulse_end", frame_done, 0);

        // Same frame, ready toggling, with valid held and the source holding data.
        for (int i = 1; i <= 6; i++) begin
            applyStimulus(1'b1, 1'b0, i == 1, i == 6, 8'(i));
            applyStimulus(1'b1, 1'b1, i == 1, i == 6, 8'(i));
        end
        checkOutput("tog_done", frame_done, 1);
        checkOutput("tog_ok", frame_ok, 1);
        checkOutput("tog_csum", checksum, 21);
        checkOutput("tog_count", frame_count, 2);

        // Short frame: eop on the 4th beat.
        for (int i = 1; i <= 4; i++)
            applyStimulus(1'b1, 1'b1, i == 1, i == 4, 8'(i));
        checkOutput("short_done", frame_done, 1);
        checkOutput("short_err", err_short, 1);
        checkOutput("short_ok", frame_ok, 0);
        checkOutput("short_csum", checksum, 10);
        checkOutput("short_count", frame_count, 2);
        checkOutput("short_sticky", err_sticky, 4'b0001);
        clr = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        clr = 1'b0;
        checkOutput("clr_sticky", err_sticky, 0);
        checkOutput("clr_count", frame_count, 0);

        // Long frame: six beats without eop, then two orphan beats.
        for (int i = 1; i <= 6; i++)
            applyStimulus(1'b1, 1'b1, i == 1, 1'b0, 8'(i));
        checkOutput("long_err", err_long, 1);
        checkOutput("long_done", frame_done, 1);
        checkOutput("long_ok", frame_ok, 0);
        checkOutput("long_csum", checksum, 21);
        checkOutput("long_inframe", in_frame, 0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'd7);
        checkOutput("orphan7", err_orphan, 1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'd8);
        checkOutput("orphan8", err_orphan, 1);
        checkOutput("long_sticky", err_sticky, 4'b1010);
        clr = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        checkOutput("clr2_sticky", err_sticky, 0);
        // The orphan pulse wins over a coincident clr.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'd9);
        checkOutput("clr_vs_set", err_sticky, 4'b1000);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        clr = 1'b0;
        checkOutput("clr3_sticky", err_sticky, 0);

        // A sop on beat 3 aborts the frame and starts a correct one.
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 8'd1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'd2);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 8'd10);
        checkOutput("sop_err", err_sop, 1);
        checkOutput("sop_done", frame_done, 1);
        checkOutput("sop_ok", frame_ok, 0);
        checkOutput("sop_csum", checksum, 3);
        checkOutput("sop_inframe", in_frame, 1);
        for (int i = 11; i <= 15; i++)
            applyStimulus(1'b1, 1'b1, 1'b0, i == 15, 8'(i));
        checkOutput("sop_good_ok", frame_ok, 1);
        checkOutput("sop_good_csum", checksum, 75);
        checkOutput("sop_good_count", frame_count, 1);
        checkOutput("sop_sticky", err_sticky, 4'b0100);

        // clr on the last beat of a good frame leaves the counter at one.
        for (int i = 0; i < 6; i++) begin
            clr = (i == 5);
            applyStimulus(1'b1, 1'b1, i == 0, i == 5, 8'(i + 1));
        end
        clr = 1'b0;
        checkOutput("clr_good_count", frame_count, 1);
        checkOutput("clr_good_sticky", err_sticky, 0);

        // srst in the middle of a frame.
        for (int i = 1; i <= 3; i++)
            applyStimulus(1'b1, 1'b1, i == 1, 1'b0, 8'(i));
        srst = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        srst = 1'b0;
        checkOutput("srst_done", frame_done, 0);
        checkOutput("srst_inframe", in_frame, 0);
        checkOutput("srst_count", frame_count, 0);
        checkOutput("srst_csum", checksum, 0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'd4);
        checkOutput("srst_orphan", err_orphan, 1);

        // The frame counter wraps from 3 to 0.
        for (int f = 0; f < 3; f++)
            sendGoodFrame(8'd1);
        checkOutput("wrap_pre", frame_count, 3);
        sendGoodFrame(8'd1);
        checkOutput("wrap_post", frame_count, 0);

`ifdef VIDEO_FRAME_CHECK_MINMAX_EN
        mm_pix = '{8'd9, 8'd2, 8'd7, 8'd2, 8'd5, 8'd3};
        for (int i = 0; i < 6; i++)
            applyStimulus(1'b1, 1'b1, i == 0, i == 5, mm_pix[i]);
        checkOutput("mm_csum", checksum, 28);
        checkOutput("mm_min", pix_min, 2);
        checkOutput("mm_max", pix_max, 9);
`endif

        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        $display("test done: total=%0d bad=%0d", total_count, bad_count);
        $finish;
    end

endmodule
